dma_xfer_engine: RTL and testbench
==================================

Name: dma_xfer_engine

Overview:
- Transfer engine downstream of the DMA register block.
- Consumes the programmed source address, destination address, length and the control start/abort strobes.
- Moves 32-bit words from source to destination over a simple req/gnt memory port, one word at a time (read then write).
- Returns busy/done/error/progress status to the register block and a one-cycle interrupt pulse.

Parameters:
- ADDR_W, 32, byte address width of src/dst and memory port.
- DATA_W, 32, word width; address step is DATA_W/8 bytes.
- LEN_W, 16, width of transfer length in words.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle strobe from CTRL register write
- abort  input  1  one-cycle strobe from CTRL register write
- src_addr  input  ADDR_W  source byte address, sampled on accepted start
- dst_addr  input  ADDR_W  destination byte address, sampled on accepted start
- xfer_len  input  LEN_W  number of words, sampled on accepted start
- busy  output  1  transfer in progress
- done  output  1  sticky: last transfer ended (ok/error/abort); cleared by accepted start
- aborted  output  1  sticky: last transfer ended by abort
- err_code  output  2  sticky: 0 none, 1 misaligned, 2 read error, 3 write error
- words_done  output  LEN_W  words fully written in current/last transfer
- irq  output  1  one-cycle pulse when done rises
- rd_req  output  1  read request
- rd_addr  output  ADDR_W  read byte address
- rd_gnt  input  1  read request accepted
- rd_valid  input  1  read data return
- rd_data  input  DATA_W  read data
- rd_err  input  1  read error, qualified by rd_valid
- wr_req  output  1  write request
- wr_addr  output  ADDR_W  write byte address
- wr_data  output  DATA_W  write data
- wr_gnt  input  1  write accepted and complete
- wr_err  input  1  write error, qualified by wr_gnt

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM IDLE, abort latch clear. A reset mid-transfer drops rd_req/wr_req immediately; no completion is reported.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
- IDLE:
  - start accepted → latch src/dst/len; clear done, aborted, err_code, words_done; busy=1 next cycle.
  - Misaligned src or dst (low log2(DATA_W/8) bits nonzero) → FINISH with err_code=1, no memory access.
  - xfer_len==0 → FINISH with err_code=0, no memory access.
  - Otherwise → RD_REQ.
- RD_REQ: rd_req=1, rd_addr=current src. Held stable until rd_gnt. On gnt → RD_WAIT; rd_req drops the cycle after gnt.
- RD_WAIT: wait for rd_valid.
  - rd_err=1 → FINISH with err_code=2.
  - Otherwise capture rd_data → WR_REQ.
- WR_REQ: wr_req=1, wr_addr=current dst, wr_data=captured word. Held stable until wr_gnt.
  - On gnt with wr_err=1 → FINISH with err_code=3; words_done not incremented.
  - On gnt with wr_err=0: words_done+1; src and dst advance by DATA_W/8.
  - Then: words_done==len → FINISH; abort latched → FINISH with aborted=1; else → RD_REQ.
- FINISH: one cycle. busy=0, done=1, irq=1 for this cycle → IDLE.
- Minimum per-word cost with zero-wait gnt/valid: 3 cycles. Start-to-first-rd_req latency: 1 cycle.
- Abort:
  - In a busy state, abort sets a latch. It is honoured only at a word boundary (after wr_gnt); a request is never withdrawn once asserted.
  - In IDLE, abort is ignored.
  - Same-cycle start+abort in IDLE: start accepted, abort ignored.
  - Abort coinciding with the final wr_gnt: normal completion, aborted=0.
- start while busy is ignored; latched parameters are unchanged.
- Address increment wraps modulo 2^ADDR_W silently.
- words_done holds its final value after FINISH until the next accepted start.

Optional Feature:
- Macro DMA_FIXED_ADDR_EN.
- Defined: adds input ports src_fixed and dst_fixed (1 bit each), sampled on accepted start. When set, the respective address does not increment (peripheral FIFO mode). Alignment is still checked.
- Undefined: ports absent; both addresses always increment.

Test Plan:
- Basic copy: src=0x1000, dst=0x2000, len=4, zero-wait memory → reads 0x1000..0x100C, writes 0x2000..0x200C with matching data; words_done=4; done=1, irq pulse, err_code=0; 12 cycles from first rd_req to FINISH.
- Zero length: len=0 → FINISH 1 cycle after start; no rd_req/wr_req; done=1, words_done=0.
- Misaligned: src=0x1002 → err_code=1, done=1, no memory requests.
- Read error: len=3, rd_err on word 2 → err_code=2, words_done=1, only one write issued.
- Abort with backpressure: len=8, wr_gnt delayed 5 cycles, abort pulsed during word 3's WR_REQ → word 3 completes; aborted=1, words_done=3; wr_req held stable throughout.
- Edge cases: start during busy ignored; dst=0xFFFFFFFC, len=2 → second write at 0x00000000; rst_n asserted in WR_REQ → wr_req drops asynchronously, all status 0.

Source files
------------

// File: rtl/dma_xfer_engine.sv
// DMA transfer engine: copies xfer_len 32-bit words from src to dst over a req/gnt port.
// Optional DMA_FIXED_ADDR_EN adds src_fixed/dst_fixed for non-incrementing (FIFO) addresses.
module dma_xfer_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  xfer_len,
`ifdef DMA_FIXED_ADDR_EN
  input  logic              src_fixed,
  input  logic              dst_fixed,
`endif
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [1:0]        err_code,
  output logic [LEN_W-1:0]  words_done,
  output logic              irq,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_err,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_gnt,
  input  logic              wr_err
);
  localparam int                STEP_B = DATA_W / 8;
  localparam int                AL     = $clog2(STEP_B);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(STEP_B);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, words_q, words_inc;
  logic [DATA_W-1:0] data_q;
  logic              abort_q, done_q, aborted_q;
  logic [1:0]        err_q, err_nxt;
  logic              start_ok, misalign, wr_ok, set_abt, in_busy;
  logic              fix_src_q, fix_dst_q;

  assign in_busy   = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);
  assign start_ok  = (state == IDLE) && start;
  assign misalign  = (|src_addr[AL-1:0]) | (|dst_addr[AL-1:0]);
  assign wr_ok     = (state == WR_REQ) && wr_gnt && !wr_err;
  assign words_inc = words_q + LEN_W'(1);

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    set_abt   = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (misalign) begin
          state_nxt = FINISH;
          err_nxt   = 2'd1;
        end else if (xfer_len == '0) begin
          state_nxt = FINISH;
          err_nxt   = 2'd0;
        end else begin
          state_nxt = RD_REQ;
          err_nxt   = 2'd0;
        end
      end
      RD_REQ:  if (rd_gnt) state_nxt = RD_WAIT;
      RD_WAIT: if (rd_valid) begin
        if (rd_err) begin
          state_nxt = FINISH;
          err_nxt   = 2'd2;
        end else begin
          state_nxt = WR_REQ;
        end
      end
      WR_REQ: if (wr_gnt) begin
        if (wr_err) begin
          state_nxt = FINISH;
          err_nxt   = 2'd3;
        end else if (words_inc == len_q) begin
          // last word wins over a coincident abort
          state_nxt = FINISH;
        end else if (abort_q || abort) begin
          state_nxt = FINISH;
          set_abt   = 1'b1;
        end else begin
          state_nxt = RD_REQ;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      err_q     <= 2'd0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      words_q   <= '0;
      data_q    <= '0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (start_ok) begin
        src_q     <= src_addr;
        dst_q     <= dst_addr;
        len_q     <= xfer_len;
        words_q   <= '0;
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
        abort_q   <= 1'b0;
      end
      if (state_nxt == FINISH) done_q <= 1'b1;
      if (set_abt) aborted_q <= 1'b1;
      if (in_busy && abort) abort_q <= 1'b1;
      else if (state == FINISH) abort_q <= 1'b0;
      if ((state == RD_WAIT) && rd_valid && !rd_err) data_q <= rd_data;
      if (wr_ok) begin
        words_q <= words_inc;
        if (!fix_src_q) src_q <= src_q + STEP;
        if (!fix_dst_q) dst_q <= dst_q + STEP;
      end
    end
  end

`ifdef DMA_FIXED_ADDR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fix_src_q <= 1'b0;
      fix_dst_q <= 1'b0;
    end else if (start_ok) begin
      fix_src_q <= src_fixed;
      fix_dst_q <= dst_fixed;
    end
  end
`else
  assign fix_src_q = 1'b0;
  assign fix_dst_q = 1'b0;
`endif

  // requests decode straight from state so a reset drops them without waiting for a clock
  assign busy       = in_busy;
  assign irq        = (state == FINISH);
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign err_code   = err_q;
  assign words_done = words_q;
  assign rd_req     = (state == RD_REQ);
  assign rd_addr    = src_q;
  assign wr_req     = (state == WR_REQ);
  assign wr_addr    = dst_q;
  assign wr_data    = data_q;
endmodule

// File: tb/tb_dma_xfer_engine.sv
// Directed bench for dma_xfer_engine with a small zero-wait / backpressure memory model.
module tb_dma_xfer_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] xfer_len = '0;
  logic        busy, done, aborted, irq;
  logic [1:0]  err_code;
  logic [15:0] words_done;
  logic        rd_req, rd_gnt, rd_valid, rd_err;
  logic [31:0] rd_addr, rd_data;
  logic        wr_req, wr_gnt, wr_err;
  logic [31:0] wr_addr, wr_data;

  int tests = 0, fails = 0;
  int wr_delay = 0, wr_cnt;
  bit wr_err_en = 0, rd_err_en = 0;
  logic [31:0] rd_err_addr = '0;
  logic [31:0] rd_log[$], wa_log[$], wd_log[$];
  int unstable;
  logic pend;
  logic [31:0] pa, pd;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  always #5 clk = ~clk;

  dma_xfer_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .xfer_len(xfer_len),
`ifdef DMA_FIXED_ADDR_EN
    .src_fixed(1'b0), .dst_fixed(1'b0),
`endif
    .busy(busy), .done(done), .aborted(aborted), .err_code(err_code),
    .words_done(words_done), .irq(irq),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_err(wr_err)
  );

  assign rd_gnt = rd_req;
  assign wr_gnt = wr_req && (wr_cnt >= wr_delay);
  assign wr_err = wr_gnt && wr_err_en;

  // memory model: read data is address ^ PAT, returned the cycle after grant
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      wr_cnt   <= 0;
      pend     <= 1'b0;
    end else begin
      rd_valid <= rd_req && rd_gnt;
      rd_data  <= rd_addr ^ PAT;
      rd_err   <= rd_req && rd_gnt && rd_err_en && (rd_addr == rd_err_addr);
      wr_cnt   <= (wr_req && !wr_gnt) ? wr_cnt + 1 : 0;
      if (rd_req && rd_gnt) rd_log.push_back(rd_addr);
      if (wr_req && wr_gnt) begin
        wa_log.push_back(wr_addr);
        wd_log.push_back(wr_data);
      end
      if (wr_req) begin
        if (pend && (wr_addr !== pa || wr_data !== pd)) unstable++;
        pend <= !wr_gnt;
        pa   <= wr_addr;
        pd   <= wr_data;
      end else begin
        pend <= 1'b0;
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    unstable = 0; wr_delay = 0; wr_err_en = 0; rd_err_en = 0;
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                          input logic ab);
    src_addr = s; dst_addr = d; xfer_len = l; start = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (irq !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (irq !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if ({busy, done, aborted, irq, rd_req, wr_req} !== 6'b0) begin fails++;
      $display("FAIL reset_flags: got %b want 000000", {busy, done, aborted, irq, rd_req, wr_req}); end
    tests++; if ({err_code, words_done, rd_addr, wr_addr, wr_data} !== '0) begin fails++;
      $display("FAIL reset_values: err %0d words %0d rd_addr %h wr_addr %h not all zero",
               err_code, words_done, rd_addr, wr_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_copy();
    int n;
    clear_logs();
    do_start(32'h1000, 32'h2000, 16'd4, 1'b0);
    tests++; if (rd_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin fails++;
      $display("FAIL basic_latency: rd_req %b busy %b done %b want 1 1 0", rd_req, busy, done); end
    tests++; if (rd_addr !== 32'h1000) begin fails++;
      $display("FAIL basic_rd_addr0: got %h want 00001000", rd_addr); end
    wait_irq(n);
    tests++; if (n != 12) begin fails++;
      $display("FAIL basic_cycles: got %0d want 12", n); end
    tests++; if (done !== 1'b1 || busy !== 1'b0 || err_code !== 2'd0 || aborted !== 1'b0) begin fails++;
      $display("FAIL basic_status: done %b busy %b err %0d aborted %b want 1 0 0 0",
               done, busy, err_code, aborted); end
    tests++; if (words_done !== 16'd4) begin fails++;
      $display("FAIL basic_words: got %0d want 4", words_done); end
    tests++; if (rd_log.size() != 4 || wa_log.size() != 4) begin fails++;
      $display("FAIL basic_count: reads %0d writes %0d want 4 4", rd_log.size(), wa_log.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra, wa;
      ra = 32'h1000 + 32'(4 * i);
      wa = 32'h2000 + 32'(4 * i);
      tests++; if (rd_log[i] !== ra || wa_log[i] !== wa || wd_log[i] !== (ra ^ PAT)) begin fails++;
        $display("FAIL basic_word%0d: rd %h wr %h data %h want %h %h %h",
                 i, rd_log[i], wa_log[i], wd_log[i], ra, wa, ra ^ PAT); end
    end
    @(negedge clk);
    tests++; if (irq !== 1'b0 || done !== 1'b1 || words_done !== 16'd4) begin fails++;
      $display("FAIL basic_after: irq %b done %b words %0d want 0 1 4", irq, done, words_done); end
  endtask

  task automatic test_zero_len();
    clear_logs();
    do_start(32'h1000, 32'h2000, 16'd0, 1'b0);
    tests++; if (irq !== 1'b1 || done !== 1'b1 || err_code !== 2'd0 || words_done !== 16'd0) begin fails++;
      $display("FAIL zero_finish: irq %b done %b err %0d words %0d want 1 1 0 0",
               irq, done, err_code, words_done); end
    @(negedge clk);
    tests++; if (rd_log.size() != 0 || wa_log.size() != 0 || irq !== 1'b0) begin fails++;
      $display("FAIL zero_noreq: reads %0d writes %0d irq %b want 0 0 0", rd_log.size(), wa_log.size(), irq); end
  endtask

  task automatic test_misaligned();
    clear_logs();
    do_start(32'h1002, 32'h2000, 16'd4, 1'b0);
    tests++; if (irq !== 1'b1 || done !== 1'b1 || err_code !== 2'd1) begin fails++;
      $display("FAIL misalign_status: irq %b done %b err %0d want 1 1 1", irq, done, err_code); end
    repeat (2) @(negedge clk);
    tests++; if (rd_log.size() != 0 || wa_log.size() != 0 || err_code !== 2'd1) begin fails++;
      $display("FAIL misalign_noreq: reads %0d writes %0d err %0d want 0 0 1",
               rd_log.size(), wa_log.size(), err_code); end
  endtask

  task automatic test_rd_err();
    int n;
    clear_logs();
    rd_err_en = 1; rd_err_addr = 32'h3004;
    do_start(32'h3000, 32'h4000, 16'd3, 1'b0);
    wait_irq(n);
    tests++; if (n != 5 || err_code !== 2'd2 || words_done !== 16'd1) begin fails++;
      $display("FAIL rderr_status: cycles %0d err %0d words %0d want 5 2 1", n, err_code, words_done); end
    tests++; if (wa_log.size() != 1 || wa_log[0] !== 32'h4000) begin fails++;
      $display("FAIL rderr_writes: count %0d addr %h want 1 00004000", wa_log.size(), wa_log[0]); end
    @(negedge clk);
  endtask

  task automatic test_wr_err();
    int n;
    clear_logs();
    wr_err_en = 1;
    do_start(32'h3000, 32'h4000, 16'd2, 1'b0);
    wait_irq(n);
    tests++; if (n != 3 || err_code !== 2'd3 || words_done !== 16'd0) begin fails++;
      $display("FAIL wrerr_status: cycles %0d err %0d words %0d want 3 3 0", n, err_code, words_done); end
    @(negedge clk);
  endtask

  task automatic test_abort_backpressure();
    int n;
    clear_logs();
    wr_delay = 5;
    do_start(32'h5000, 32'h6000, 16'd8, 1'b0);
    n = 0;
    while (!(wr_req === 1'b1 && wa_log.size() == 2) && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    tests++; if (wr_req !== 1'b1 || wr_addr !== 32'h6008) begin fails++;
      $display("FAIL abort_in_wr: wr_req %b addr %h want 1 00006008", wr_req, wr_addr); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_irq(n);
    tests++; if (n < 0 || aborted !== 1'b1 || words_done !== 16'd3 || err_code !== 2'd0) begin fails++;
      $display("FAIL abort_status: cycles %0d aborted %b words %0d err %0d want >=0 1 3 0",
               n, aborted, words_done, err_code); end
    tests++; if (wa_log.size() != 3 || rd_log.size() != 3 || wd_log[2] !== (32'h5008 ^ PAT)) begin fails++;
      $display("FAIL abort_traffic: writes %0d reads %0d data %h want 3 3 %h",
               wa_log.size(), rd_log.size(), wd_log[2], 32'h5008 ^ PAT); end
    tests++; if (unstable != 0) begin fails++;
      $display("FAIL abort_wr_stable: got %0d changes want 0", unstable); end
    @(negedge clk);
  endtask

  task automatic test_abort_last();
    int n;
    clear_logs();
    wr_delay = 3;
    do_start(32'h5000, 32'h6000, 16'd2, 1'b0);
    n = 0;
    while (!(wr_gnt === 1'b1 && wa_log.size() == 1) && n < 200) begin @(negedge clk); n++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_irq(n);
    tests++; if (n < 0 || aborted !== 1'b0 || words_done !== 16'd2 || err_code !== 2'd0) begin fails++;
      $display("FAIL abortlast_status: cycles %0d aborted %b words %0d err %0d want >=0 0 2 0",
               n, aborted, words_done, err_code); end
    @(negedge clk);
  endtask

  task automatic test_start_abort_same();
    int n;
    clear_logs();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    do_start(32'h1000, 32'h2000, 16'd2, 1'b1);
    wait_irq(n);
    tests++; if (n != 6 || aborted !== 1'b0 || words_done !== 16'd2) begin fails++;
      $display("FAIL startabort: cycles %0d aborted %b words %0d want 6 0 2", n, aborted, words_done); end
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    int n;
    clear_logs();
    do_start(32'h7000, 32'h8000, 16'd3, 1'b0);
    src_addr = 32'h9000; dst_addr = 32'hA000; xfer_len = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_irq(n);
    tests++; if (n != 8 || words_done !== 16'd3 || wa_log.size() != 3) begin fails++;
      $display("FAIL busystart_len: cycles %0d words %0d writes %0d want 8 3 3", n, words_done, wa_log.size()); end
    tests++; if (rd_log[2] !== 32'h7008 || wa_log[2] !== 32'h8008) begin fails++;
      $display("FAIL busystart_addr: rd %h wr %h want 00007008 00008008", rd_log[2], wa_log[2]); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int n;
    clear_logs();
    do_start(32'h100, 32'hFFFF_FFFC, 16'd2, 1'b0);
    wait_irq(n);
    tests++; if (wa_log.size() != 2 || wa_log[0] !== 32'hFFFF_FFFC || wa_log[1] !== 32'h0) begin fails++;
      $display("FAIL wrap_addr: count %0d a0 %h a1 %h want 2 fffffffc 00000000",
               wa_log.size(), wa_log[0], wa_log[1]); end
    tests++; if (wd_log[1] !== (32'h104 ^ PAT) || words_done !== 16'd2) begin fails++;
      $display("FAIL wrap_data: data %h words %0d want %h 2", wd_log[1], words_done, 32'h104 ^ PAT); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    wr_delay = 5;
    do_start(32'h1000, 32'h2000, 16'd4, 1'b0);
    n = 0;
    while (wr_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    tests++; if (wr_req !== 1'b1) begin fails++;
      $display("FAIL rstmid_reach: wr_req %b want 1", wr_req); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({wr_req, rd_req, busy, done, aborted, irq} !== 6'b0) begin fails++;
      $display("FAIL rstmid_flags: got %b want 000000", {wr_req, rd_req, busy, done, aborted, irq}); end
    tests++; if ({err_code, words_done, wr_addr, wr_data} !== '0) begin fails++;
      $display("FAIL rstmid_values: err %0d words %0d wr_addr %h wr_data %h not zero",
               err_code, words_done, wr_addr, wr_data); end
    @(negedge clk);
    rst_n = 1'b1; wr_delay = 0;
    n = 0;
    repeat (5) begin @(negedge clk); if (irq === 1'b1 || busy === 1'b1) n++; end
    tests++; if (n != 0 || done !== 1'b0) begin fails++;
      $display("FAIL rstmid_idle: active cycles %0d done %b want 0 0", n, done); end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_len();
    test_misaligned();
    test_rd_err();
    test_wr_err();
    test_abort_backpressure();
    test_abort_last();
    test_start_abort_same();
    test_start_busy();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
